// File: rtl/fir_pkg.sv
// Shared types and constants for the single-MAC FIR sequencer and its datapath.
package fir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    localparam int TAP_NUM_DEF = 11;
    localparam int WORD_BYTES  = 4;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate for the FIR engine: one product per enabled cycle, registered accumulator.
// FIR_SAT_EN selects saturating accumulation; otherwise the sum wraps.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] tap,
    input  logic [DW-1:0] dat,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] prod;
    logic [DW-1:0] sum;
    logic [DW-1:0] acc_next;

    // Low DW bits of a product do not depend on operand signedness.
    assign prod = tap * dat;
    assign sum  = acc + prod;

`ifdef FIR_SAT_EN
    logic ovf;
    assign ovf = (acc[DW-1] == prod[DW-1]) && (sum[DW-1] != acc[DW-1]);

    always_comb begin
        acc_next = sum;
        if (ovf) begin
            acc_next = acc[DW-1] ? DW'(SAT_MIN) : DW'(SAT_MAX);
        end
    end
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_tap_sched.sv
// FIR sequencer: clears the data ring, takes one sample per ss handshake, walks TAP_NUM taps,
// emits one result TAP_NUM+2 cycles after the input handshake; sm backpressure stalls only OUT.
module fir_tap_sched
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int TAP_NUM     = TAP_NUM_DEF
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic                   data_we,
    output logic [pADDR_WIDTH-1:0] data_addr,
    output logic [pDATA_WIDTH-1:0] data_wdata,
    input  logic [pDATA_WIDTH-1:0] data_rdata,
    output logic [pADDR_WIDTH-1:0] tap_addr,
    input  logic [pDATA_WIDTH-1:0] tap_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   tlast_err
);

    localparam int IW = $clog2(TAP_NUM + 1);
    localparam logic [IW-1:0] LAST  = IW'(TAP_NUM - 1);
    localparam logic [IW-1:0] DRAIN = IW'(TAP_NUM);

    state_t                 state;
    logic [IW-1:0]          k;
    logic [IW-1:0]          head;
    logic [31:0]            cnt;
    logic [31:0]            len;
    logic [pDATA_WIDTH-1:0] sample;
    logic                   mac_clr;
    logic                   mac_en;
    logic [pDATA_WIDTH-1:0] mac_dat;

    function automatic logic [pADDR_WIDTH-1:0] waddr(input logic [IW-1:0] idx);
        return pADDR_WIDTH'(idx) * pADDR_WIDTH'(WORD_BYTES);
    endfunction

    function automatic logic [IW-1:0] ring_idx(input logic [IW-1:0] h, input logic [IW-1:0] d);
        return (h >= d) ? (h - d) : (h + IW'(TAP_NUM) - d);
    endfunction

    assign ss_tready = (state == S_WAIT_IN);

    // The newest sample is written and read at the same address in the same cycle,
    // so its product takes the registered copy rather than relying on RAM collision behaviour.
    assign mac_clr = (state == S_WAIT_IN) && ss_tvalid;
    assign mac_en  = (state == S_MAC) && (k != '0);
    assign mac_dat = (k == IW'(1)) ? sample : data_rdata;

    fir_mac #(.DW(pDATA_WIDTH)) u_mac (
        .clk (axis_clk),
        .rst (axis_rst),
        .clr (mac_clr),
        .en  (mac_en),
        .tap (tap_rdata),
        .dat (mac_dat),
        .acc (sm_tdata)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state      <= S_IDLE;
            k          <= '0;
            head       <= '0;
            cnt        <= '0;
            len        <= '0;
            sample     <= '0;
            sm_tvalid  <= 1'b0;
            sm_tlast   <= 1'b0;
            data_we    <= 1'b0;
            data_addr  <= '0;
            data_wdata <= '0;
            tap_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tlast_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len        <= data_length;
                        cnt        <= '0;
                        tlast_err  <= 1'b0;
                        k          <= '0;
                        data_we    <= 1'b1;
                        data_addr  <= waddr('0);
                        data_wdata <= '0;
                        busy       <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (k == LAST) begin
                        data_we <= 1'b0;
                        head    <= '0;
                        k       <= '0;
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT_IN;
                        end
                    end else begin
                        k         <= k + IW'(1);
                        data_addr <= waddr(k + IW'(1));
                    end
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        sample     <= ss_tdata;
                        data_we    <= 1'b1;
                        data_addr  <= waddr(head);
                        data_wdata <= ss_tdata;
                        tap_addr   <= waddr('0);
                        k          <= '0;
                        if (ss_tlast != (cnt + 32'd1 == len)) begin
                            tlast_err <= 1'b1;
                        end
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    data_we <= 1'b0;
                    // k == DRAIN is the cycle the last read returns; addresses stop at LAST.
                    if (k == DRAIN) begin
                        head      <= (head == LAST) ? '0 : head + IW'(1);
                        k         <= '0;
                        sm_tvalid <= 1'b1;
                        sm_tlast  <= (cnt + 32'd1 == len);
                        state     <= S_OUT;
                    end else begin
                        k <= k + IW'(1);
                        if (k != LAST) begin
                            tap_addr  <= waddr(k + IW'(1));
                            data_addr <= waddr(ring_idx(head, k + IW'(1)));
                        end
                    end
                end
                S_OUT: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        cnt       <= cnt + 32'd1;
                        if (cnt + 32'd1 == len) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT_IN;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
